// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg
// Shared CPU datapath types: data word and atomic request unit states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [29:0] waddr_t;

    localparam word_t SC_PASS = 32'h0000_0001;
    localparam word_t SC_FAIL_VAL = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR      = 2'd2,
        SC_FAIL = 2'd3
    } req_state_t;

endpackage

`default_nettype wire

// File: rtl/link_register.sv
// ============================================================================
// link_register
// LL/SC reservation: word address plus valid bit, cleared by SC, matching
// stores and matching remote-write snoops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module link_register
    import cpu_types_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   set,
    input  waddr_t set_addr,
    input  logic   clr,
    input  logic   store_chk,
    input  waddr_t store_addr,
    input  logic   snoop_valid,
    input  waddr_t snoop_addr,
    input  waddr_t chk_addr,
    output logic   link_hit
);

    logic   r_valid;
    waddr_t r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (set) begin
            // A snoop to the word being linked this cycle kills the new link
            r_addr  <= set_addr;
            r_valid <= !(snoop_valid && (snoop_addr == set_addr));
        end else if (clr ||
                     (store_chk && (store_addr == r_addr)) ||
                     (snoop_valid && (snoop_addr == r_addr))) begin
            r_valid <= 1'b0;
        end
    end

    assign link_hit = r_valid && (chk_addr == r_addr);

endmodule

`default_nettype wire

// File: rtl/atomic_request_unit.sv
// ============================================================================
// atomic_request_unit
// Data-side request sequencer for loads, stores and LL/SC atomics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module atomic_request_unit
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  dREN_in,
    input  logic  dWEN_in,
    input  logic  datomic_in,
    input  logic  ihit,
    input  word_t daddr_in,
    input  word_t dstore_in,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  snoop_valid,
    input  word_t snoop_addr,
    output logic  busy,
    output logic  ddone,
    output word_t dload
);

    req_state_t r_state;
    req_state_t w_next_state;

    logic  w_accept;
    logic  w_rd_done;
    logic  w_wr_done;
    logic  w_sc_fail;
    logic  w_link_hit;
    logic  w_unused;

    word_t r_addr;
    word_t r_store;
    logic  r_atomic;
    logic  r_ddone;
    word_t r_dload;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rd_done    = 1'b0;
        w_wr_done    = 1'b0;
        w_sc_fail    = 1'b0;
        case (r_state)
            IDLE: begin
                // Read has priority when both decode flags are set
                if (ihit && dREN_in) begin
                    w_accept     = 1'b1;
                    w_next_state = RD;
                end else if (ihit && dWEN_in) begin
                    w_accept     = 1'b1;
                    w_next_state = (!datomic_in || w_link_hit) ? WR : SC_FAIL;
                end
            end
            RD: begin
                if (dhit) begin
                    w_rd_done    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            WR: begin
                if (dhit) begin
                    w_wr_done    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            SC_FAIL: begin
                w_sc_fail    = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_addr   <= '0;
            r_store  <= '0;
            r_atomic <= 1'b0;
            r_ddone  <= 1'b0;
            r_dload  <= '0;
        end else begin
            r_ddone <= w_rd_done || w_wr_done || w_sc_fail;
            if (w_accept) begin
                r_addr   <= daddr_in;
                r_store  <= dstore_in;
                r_atomic <= datomic_in;
            end
            if (w_rd_done) begin
                r_dload <= dmemload;
            end else if (w_wr_done && r_atomic) begin
                r_dload <= SC_PASS;
            end else if (w_sc_fail) begin
                r_dload <= SC_FAIL_VAL;
            end
        end
    end

    link_register u_link (
        .clk         (CLK),
        .rst         (nRST),
        .set         (w_rd_done && r_atomic),
        .set_addr    (r_addr[31:2]),
        .clr         (w_wr_done && r_atomic),
        .store_chk   (w_wr_done && !r_atomic),
        .store_addr  (r_addr[31:2]),
        .snoop_valid (snoop_valid),
        .snoop_addr  (snoop_addr[31:2]),
        .chk_addr    (daddr_in[31:2]),
        .link_hit    (w_link_hit)
    );

    assign w_unused  = &{1'b0, snoop_addr[1:0]};

    assign dmemREN   = (r_state == RD);
    assign dmemWEN   = (r_state == WR);
    assign dmemaddr  = r_addr;
    assign dmemstore = r_store;
    assign ddone     = r_ddone;
    assign dload     = r_dload;
    assign busy      = (r_state != IDLE) || (ihit && (dREN_in || dWEN_in));

endmodule

`default_nettype wire

// File: tb/tb_atomic_request_unit.sv
// ============================================================================
// tb_atomic_request_unit
// Directed self-checking bench for loads, stores, LL/SC, snoops and reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_atomic_request_unit;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  dREN_in, dWEN_in, datomic_in, ihit, dhit, snoop_valid;
    word_t daddr_in, dstore_in, dmemload, snoop_addr;
    logic  dmemREN, dmemWEN, busy, ddone;
    word_t dmemaddr, dmemstore, dload;

    int vectors = 0;
    int miscompares = 0;

    int    ren_cyc, wen_cyc, done_cnt, done_at;
    word_t got_load, got_store, got_addr;

    atomic_request_unit dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dREN_in     (dREN_in),
        .dWEN_in     (dWEN_in),
        .datomic_in  (datomic_in),
        .ihit        (ihit),
        .daddr_in    (daddr_in),
        .dstore_in   (dstore_in),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .dhit        (dhit),
        .dmemload    (dmemload),
        .snoop_valid (snoop_valid),
        .snoop_addr  (snoop_addr),
        .busy        (busy),
        .ddone       (ddone),
        .dload       (dload)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: accepted on the next edge, dhit raised once the memory
    // strobe has been seen for lat cycles; optional snoop on the dhit cycle.
    task automatic req(input logic r, input logic w, input logic a, input word_t addr,
                       input word_t data, input word_t rdata, input int lat, input logic snp);
        ren_cyc = 0; wen_cyc = 0; done_cnt = 0; done_at = -1;
        got_load = '0; got_store = '0; got_addr = '0;
        dREN_in = r; dWEN_in = w; datomic_in = a; daddr_in = addr;
        dstore_in = data; dmemload = rdata; ihit = 1'b1;
        step();
        ihit = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; datomic_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (dmemREN) ren_cyc++;
            if (dmemWEN) wen_cyc++;
            if (dmemREN || dmemWEN) begin
                got_addr  = dmemaddr;
                got_store = dmemstore;
            end
            if (ddone) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
                got_load = dload;
            end
            dhit = (dmemREN || dmemWEN) && ((ren_cyc + wen_cyc) >= lat);
            snoop_valid = snp && dhit;
            snoop_addr = addr;
            step();
        end
        dhit = 1'b0;
        snoop_valid = 1'b0;
    endtask

    initial begin
        nRST = 1'b1; dREN_in = 0; dWEN_in = 0; datomic_in = 0; ihit = 0; dhit = 0;
        snoop_valid = 0; daddr_in = '0; dstore_in = '0; dmemload = '0; snoop_addr = '0;
        step(); step();
        nRST = 1'b0;
        #1;
        check("rst_dload", dload, 32'h0);
        check("rst_ddone", {31'h0, ddone}, 32'h0);
        check("rst_dmemREN", {31'h0, dmemREN}, 32'h0);
        check("rst_dmemWEN", {31'h0, dmemWEN}, 32'h0);
        check("rst_dmemaddr", dmemaddr, 32'h0);
        check("rst_dmemstore", dmemstore, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);

        dREN_in = 1'b1; #1;
        check("busy_no_ihit", {31'h0, busy}, 32'h0);
        ihit = 1'b1; #1;
        check("busy_ihit", {31'h0, busy}, 32'h1);
        ihit = 1'b0; dREN_in = 1'b0; #1;

        // Plain load, dhit on third RD cycle; first ihit after reset accepted
        req(1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
        check("lw_ren_cycles", 32'(ren_cyc), 32'd3);
        check("lw_wen_cycles", 32'(wen_cyc), 32'd0);
        check("lw_addr", got_addr, 32'h100);
        check("lw_done_cnt", 32'(done_cnt), 32'd1);
        check("lw_done_at", 32'(done_at), 32'd3);
        check("lw_dload", got_load, 32'hDEADBEEF);

        // LL then SC to the same word succeeds; a second SC fails
        req(1, 0, 1, 32'h200, 32'h0, 32'h42, 1, 0);
        check("ll_dload", got_load, 32'h42);
        req(0, 1, 1, 32'h200, 32'h5, 32'h0, 2, 0);
        check("sc_wen_cycles", 32'(wen_cyc), 32'd2);
        check("sc_store", got_store, 32'h5);
        check("sc_dload", got_load, 32'h1);
        check("sc_done_at", 32'(done_at), 32'd2);
        req(0, 1, 1, 32'h200, 32'h6, 32'h0, 1, 0);
        check("sc2_wen_cycles", 32'(wen_cyc), 32'd0);
        check("sc2_dload", got_load, 32'h0);
        check("sc2_done_at", 32'(done_at), 32'd1);

        // Snoop to linked word in IDLE breaks the link
        req(1, 0, 1, 32'h200, 32'h0, 32'h7, 1, 0);
        snoop_valid = 1'b1; snoop_addr = 32'h200;
        step();
        snoop_valid = 1'b0;
        req(0, 1, 1, 32'h200, 32'h9, 32'h0, 1, 0);
        check("snoop_sc_wen", 32'(wen_cyc), 32'd0);
        check("snoop_sc_dload", got_load, 32'h0);

        // Snoop in the same cycle as the LL completion wins
        req(1, 0, 1, 32'h200, 32'h0, 32'h8, 1, 1);
        req(0, 1, 1, 32'h200, 32'h9, 32'h0, 1, 0);
        check("snoopll_sc_wen", 32'(wen_cyc), 32'd0);
        check("snoopll_sc_dload", got_load, 32'h0);

        // Plain store to another word keeps the link
        req(1, 0, 1, 32'h200, 32'h0, 32'h1, 1, 0);
        req(0, 1, 0, 32'h204, 32'h7, 32'h0, 1, 0);
        check("sw204_wen", 32'(wen_cyc), 32'd1);
        check("sw204_dload", got_load, 32'h1);
        req(0, 1, 1, 32'h200, 32'h8, 32'h0, 1, 0);
        check("sc_after_sw204_wen", 32'(wen_cyc), 32'd1);
        check("sc_after_sw204_dload", got_load, 32'h1);

        // Plain store to the linked word breaks the link
        req(1, 0, 1, 32'h200, 32'h0, 32'h2, 1, 0);
        req(0, 1, 0, 32'h200, 32'h7, 32'h0, 1, 0);
        req(0, 1, 1, 32'h200, 32'h8, 32'h0, 1, 0);
        check("sc_after_sw200_wen", 32'(wen_cyc), 32'd0);
        check("sc_after_sw200_dload", got_load, 32'h0);

        // Reset in the middle of a read, with a live link on 0x300
        req(1, 0, 1, 32'h300, 32'h0, 32'h3, 1, 0);
        dREN_in = 1'b1; daddr_in = 32'h100; ihit = 1'b1;
        step();
        ihit = 1'b0; dREN_in = 1'b0;
        check("mid_rd_ren", {31'h0, dmemREN}, 32'h1);
        nRST = 1'b1; #1;
        check("mid_rst_ren", {31'h0, dmemREN}, 32'h0);
        check("mid_rst_addr", dmemaddr, 32'h0);
        check("mid_rst_dload", dload, 32'h0);
        step();
        check("mid_rst_ddone", {31'h0, ddone}, 32'h0);
        nRST = 1'b0;
        step();
        check("post_rst_ddone", {31'h0, ddone}, 32'h0);
        req(0, 1, 1, 32'h300, 32'h4, 32'h0, 1, 0);
        check("post_rst_sc_wen", 32'(wen_cyc), 32'd0);
        check("post_rst_sc_done_at", 32'(done_at), 32'd1);

        // Both decode flags set: read only
        req(1, 1, 0, 32'h400, 32'h55, 32'hCAFE0001, 1, 0);
        check("rw_ren", 32'(ren_cyc), 32'd1);
        check("rw_wen", 32'(wen_cyc), 32'd0);
        check("rw_dload", got_load, 32'hCAFE0001);

        // dhit while idle is ignored
        dhit = 1'b1; dmemload = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_dhit_ddone", {31'h0, ddone}, 32'h0);
        end
        dhit = 1'b0;
        check("idle_dhit_dload", dload, 32'hCAFE0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
